// File: rtl/clk_tick_gen_if.sv
// rtl/clk_tick_gen_if.sv - control and tick bundle for the multi-channel clock divider
interface clk_tick_gen_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0] CH_EN;
    logic [NUM_CH-1:0] DIV_LOAD;
    logic [CNT_W-1:0]  DIV_VALUE;
    logic              SYNC;
    logic [NUM_CH-1:0] TICK;
    logic [NUM_CH-1:0] CLK_OUT;
    logic [NUM_CH-1:0] DIV_PENDING;

    modport master (
        output CH_EN, DIV_LOAD, DIV_VALUE, SYNC,
        input  TICK, CLK_OUT, DIV_PENDING
    );

    modport slave (
        input  CH_EN, DIV_LOAD, DIV_VALUE, SYNC,
        output TICK, CLK_OUT, DIV_PENDING
    );
endinterface

// File: rtl/clk_tick_gen.sv
// rtl/clk_tick_gen.sv - NUM_CH independent clock dividers with shadowed divisors and phase sync
module clk_tick_gen #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 50
) (
    input  logic           CLK,
    input  logic           RESET,
    clk_tick_gen_if.slave  bus
);
    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0]  div_q    [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] clk_q;

    logic [CNT_W-1:0]  de   [NUM_CH];
    logic [CNT_W:0]    half [NUM_CH];
    logic [NUM_CH-1:0] tc;
    logic [NUM_CH-1:0] restart;

    // Divisors below 2 run as divide-by-2; half is one bit wider so (De+1) cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            de[i]      = (div_q[i] < CNT_W'(2)) ? CNT_W'(2) : div_q[i];
            half[i]    = ({1'b0, de[i]} + (CNT_W+1)'(1)) >> 1;
            tc[i]      = bus.CH_EN[i] && (cnt_q[i] == de[i] - CNT_W'(1));
            restart[i] = !bus.CH_EN[i] || tc[i] || bus.SYNC;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_q <= '0;
            clk_q  <= '0;
            pend_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]    <= DEF_D;
                shadow_q[i] <= DEF_D;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                tick_q[i] <= tc[i] && !bus.SYNC;
                clk_q[i]  <= bus.CH_EN[i] && ({1'b0, cnt_q[i]} < half[i]);
                cnt_q[i]  <= restart[i] ? '0 : cnt_q[i] + CNT_W'(1);
                // A load landing on terminal count goes straight to the active divisor.
                if (tc[i] && bus.DIV_LOAD[i]) begin
                    div_q[i]    <= bus.DIV_VALUE;
                    shadow_q[i] <= bus.DIV_VALUE;
                    pend_q[i]   <= 1'b0;
                end else begin
                    if (restart[i] && pend_q[i])
                        div_q[i] <= shadow_q[i];
                    if (bus.DIV_LOAD[i]) begin
                        shadow_q[i] <= bus.DIV_VALUE;
                        pend_q[i]   <= 1'b1;
                    end else if (restart[i]) begin
                        pend_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.TICK        = tick_q;
    assign bus.CLK_OUT     = clk_q;
    assign bus.DIV_PENDING = pend_q;
endmodule

// File: tb/tb_clk_tick_gen.sv
// tb/tb_clk_tick_gen.sv - table, directed and random checks of clk_tick_gen against a reference model
module tb_clk_tick_gen;
    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 50;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    clk_tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per-channel divisor, shadow, pending flag and position within the period.
    int                m_div [NUM_CH];
    int                m_sh  [NUM_CH];
    int                m_pos [NUM_CH];
    bit                m_pend[NUM_CH];
    logic [NUM_CH-1:0] e_tick, e_clk, e_pend;

    function automatic void model_step(bit r, logic [NUM_CH-1:0] en, logic [NUM_CH-1:0] ld,
                                       int v, bit s);
        for (int c = 0; c < NUM_CH; c++) begin
            int  period;
            bit  at_end, boundary;
            if (r) begin
                m_div[c] = DEF_DIV; m_sh[c] = DEF_DIV; m_pend[c] = 0; m_pos[c] = 0;
                e_tick[c] = 0; e_clk[c] = 0;
            end else begin
                period    = (m_div[c] < 2) ? 2 : m_div[c];
                at_end    = en[c] && (m_pos[c] == period - 1);
                boundary  = at_end || s || !en[c];
                e_tick[c] = at_end && !s;
                e_clk[c]  = en[c] && (m_pos[c] < (period + 1) / 2);
                m_pos[c]  = boundary ? 0 : m_pos[c] + 1;
                if (at_end && ld[c]) begin
                    m_div[c] = v; m_sh[c] = v; m_pend[c] = 0;
                end else begin
                    if (boundary && m_pend[c]) begin
                        m_div[c] = m_sh[c]; m_pend[c] = 0;
                    end
                    if (ld[c]) begin
                        m_sh[c] = v; m_pend[c] = 1;
                    end
                end
            end
            e_pend[c] = m_pend[c];
        end
    endfunction

    task automatic cmp_vec(string name, logic [NUM_CH-1:0] act, logic [NUM_CH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, step the model, sample 1ns after the edge and compare to the model.
    task automatic drive(bit r, logic [NUM_CH-1:0] en, logic [NUM_CH-1:0] ld, int v, bit s);
        RESET         = r;
        bus.CH_EN     = en;
        bus.DIV_LOAD  = ld;
        bus.DIV_VALUE = CNT_W'(v);
        bus.SYNC      = s;
        @(posedge CLK);
        model_step(r, en, ld, v, s);
        #1;
        cmp_vec("model_tick", bus.TICK, e_tick);
        cmp_vec("model_clk_out", bus.CLK_OUT, e_clk);
        cmp_vec("model_pending", bus.DIV_PENDING, e_pend);
    endtask

    typedef struct {
        bit               rst;
        logic [NUM_CH-1:0] en, ld;
        int               val;
        bit               sync;
        logic [NUM_CH-1:0] tick, clk, pend;
    } vec_t;

    vec_t tbl[25];

    initial begin
        int first, second, highs, both, first_both, k;
        bit extra;

        tbl[0]  = '{1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{0, 2'b00, 2'b01, 5, 0, 2'b00, 2'b00, 2'b01};
        tbl[2]  = '{0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00};
        tbl[4]  = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00};
        tbl[5]  = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00};
        tbl[6]  = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[7]  = '{0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00};
        tbl[8]  = '{0, 2'b01, 2'b01, 1, 0, 2'b00, 2'b01, 2'b01};
        tbl[9]  = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b01};
        tbl[10] = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b01};
        tbl[11] = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01};
        tbl[12] = '{0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00};
        tbl[13] = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00};
        tbl[14] = '{0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00};
        tbl[15] = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00};
        tbl[16] = '{0, 2'b01, 2'b01, 3, 0, 2'b01, 2'b00, 2'b00};
        tbl[17] = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00};
        tbl[18] = '{0, 2'b01, 2'b00, 0, 1, 2'b00, 2'b01, 2'b00};
        tbl[19] = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00};
        tbl[20] = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00};
        tbl[21] = '{0, 2'b01, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00};
        tbl[22] = '{0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
        tbl[23] = '{1, 2'b01, 2'b01, 9, 0, 2'b00, 2'b00, 2'b00};
        tbl[24] = '{0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00};

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].val, tbl[i].sync);
            cmp_vec($sformatf("tbl%0d_tick", i), bus.TICK, tbl[i].tick);
            cmp_vec($sformatf("tbl%0d_clk_out", i), bus.CLK_OUT, tbl[i].clk);
            cmp_vec($sformatf("tbl%0d_pending", i), bus.DIV_PENDING, tbl[i].pend);
        end

        // Default divisor out of reset: tick every 50, square wave 25 high / 25 low.
        drive(1, 2'b00, 2'b00, 0, 0);
        first = 0; second = 0; highs = 0;
        for (int j = 1; j <= 120; j++) begin
            drive(0, 2'b01, 2'b00, 0, 0);
            if (j <= 50 && bus.CLK_OUT[0]) highs++;
            if (bus.TICK[0]) begin
                if (first == 0) first = j;
                else if (second == 0) second = j;
            end
        end
        cmp_int("def_first_tick", first, 50);
        cmp_int("def_tick_period", second - first, 50);
        cmp_int("def_clk_high", highs, 25);

        // Two divisors brought into phase by SYNC meet every lcm(4,6) = 12 cycles.
        drive(1, 2'b00, 2'b00, 0, 0);
        drive(0, 2'b00, 2'b01, 4, 0);
        drive(0, 2'b00, 2'b10, 6, 0);
        drive(0, 2'b00, 2'b00, 0, 0);
        for (int j = 0; j < 7; j++) drive(0, 2'b11, 2'b00, 0, 0);
        drive(0, 2'b11, 2'b00, 0, 1);
        cmp_vec("sync_no_tick", bus.TICK, 2'b00);
        both = 0; first_both = 0; extra = 0;
        for (int j = 1; j <= 36; j++) begin
            drive(0, 2'b11, 2'b00, 0, 0);
            if (bus.TICK == 2'b11) begin
                both++;
                if (first_both == 0) first_both = j;
                if (j % 12 != 0) extra = 1;
            end
        end
        cmp_int("sync_coincident_count", both, 3);
        cmp_int("sync_first_coincident", first_both, 12);
        cmp_int("sync_off_grid", int'(extra), 0);

        // Reset mid-period with a load pending discards it and restarts at the default divisor.
        for (int j = 0; j < 10; j++) drive(0, 2'b01, 2'b00, 0, 0);
        drive(0, 2'b01, 2'b01, 5, 0);
        cmp_vec("pend_before_reset", bus.DIV_PENDING, 2'b01);
        drive(1, 2'b01, 2'b01, 7, 1);
        cmp_vec("reset_tick", bus.TICK, 2'b00);
        cmp_vec("reset_clk_out", bus.CLK_OUT, 2'b00);
        cmp_vec("reset_pending", bus.DIV_PENDING, 2'b00);
        first = 0; k = 0;
        while (first == 0 && k < 80) begin
            k++;
            drive(0, 2'b01, 2'b00, 0, 0);
            if (bus.TICK[0]) first = k;
        end
        cmp_int("reset_first_tick", first, 50);

        // Random traffic against the model.
        drive(1, 2'b00, 2'b00, 0, 0);
        for (int j = 0; j < 3000; j++) begin
            logic [NUM_CH-1:0] en, ld;
            int v;
            for (int c = 0; c < NUM_CH; c++) begin
                en[c] = ($urandom_range(0, 19) != 0);
                ld[c] = ($urandom_range(0, 24) == 0);
            end
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
            drive($urandom_range(0, 299) == 0, en, ld, v, $urandom_range(0, 39) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_tick_gen.md
CLK_TICK_GEN -- requirements
Module: clk_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent divider channels (1..8).
REQ-002 Parameter CNT_W, default 8: divisor and counter width in bits.
REQ-003 Parameter DEF_DIV, default 50: divisor loaded into every channel at reset.
REQ-004 Clocking and reset SHALL be one clock, CLK, with a synchronous, active-high reset, RESET.
REQ-005 CLK  input  1  system clock; all logic on posedge CLK, no negedge or gated logic.
REQ-006 RESET  input  1  synchronous active-high reset.
REQ-007 CH_EN  input  NUM_CH  per-channel run enable.
REQ-008 DIV_LOAD  input  NUM_CH  per-channel one-cycle strobe: capture DIV_VALUE into that channel's shadow.
REQ-009 DIV_VALUE  input  CNT_W  new divisor, shared by all channels.
REQ-010 SYNC  input  1  one-cycle strobe: restart all channels in phase.
REQ-011 TICK  output  NUM_CH  one-cycle clock-enable pulse per divided period.
REQ-012 CLK_OUT  output  NUM_CH  divided square wave, registered.
REQ-013 DIV_PENDING  output  NUM_CH  shadow divisor written but not yet active.

Function
REQ-014 Each channel SHALL hold active divisor D, shadow S, pending flag P and counter C (CNT_W bits).
REQ-015 Effective divisor De = max(D, 2); values 0 and 1 SHALL behave as 2.
REQ-016 An enabled channel SHALL count C = 0,1,..,De-1, then wrap to 0; wrap is terminal count (TC).
REQ-017 TICK SHALL be registered: TICK(t+1) = CH_EN(t) & TC(t) & ~SYNC(t); exactly one pulse per De cycles.
REQ-018 CLK_OUT SHALL be registered: CLK_OUT(t+1) = CH_EN(t) & (C(t) < H), H = (De+1)>>1; odd De gives high one cycle longer than low (De=5: 3 high, 2 low).
REQ-019 DIV_LOAD bit set SHALL write S <= DIV_VALUE and set P the next cycle; a second load before apply overwrites S.
REQ-020 With P set, D <= S and P cleared at the first of: TC, SYNC, or any cycle with CH_EN low; C restarts at 0 under the new D.
REQ-021 DIV_LOAD coincident with TC SHALL apply the just-loaded value at that boundary (load-then-apply in one cycle); P stays 0.
REQ-022 SYNC SHALL force C <= 0 on all channels the next cycle, apply any pending S, and suppress TICK for that cycle; SYNC beats coincident TC.
REQ-023 CH_EN low SHALL hold C at 0; TICK and CLK_OUT go 0 the next cycle; re-enable starts at C=0 with CLK_OUT high next cycle.
REQ-024 Channels SHALL be fully independent except for the shared DIV_VALUE and SYNC.
REQ-025 Counter arithmetic SHALL never exceed De-1; a D lowered below current C takes effect only via REQ-020, so no overrun occurs.

Reset
REQ-026 RESET SHALL set, per channel: D=DEF_DIV, S=DEF_DIV, P=0, C=0, TICK=0, CLK_OUT=0, DIV_PENDING=0.
REQ-027 RESET SHALL dominate all inputs, including mid-period and with a load pending; the pending value is discarded.
REQ-028 First TICK after RESET release with CH_EN high SHALL occur De cycles after the first enabled cycle.

Verification
REQ-029 Reset, CH_EN=1, DEF_DIV=50 -> TICK every 50 cycles; CLK_OUT 25 high / 25 low.
REQ-030 Load DIV_VALUE=5 mid-period -> DIV_PENDING=1 until TC, old period completes, then TICK every 5, CLK_OUT 3 high / 2 low.
REQ-031 DIV_VALUE=0 and DIV_VALUE=1 loaded -> both behave as divide-by-2, CLK_OUT toggles each cycle.
REQ-032 Ch0 D=4, ch1 D=6, SYNC pulse -> both C=0 next cycle, no TICK that cycle, coincident TICKs every 12 cycles thereafter.
REQ-033 CH_EN dropped mid-period with load pending -> TICK/CLK_OUT 0 next cycle, P cleared, new D used on re-enable.
REQ-034 RESET asserted mid-period with P=1 -> all outputs 0, D reverts to DEF_DIV, first TICK 50 cycles after enable.
